thread_scheduler: RTL and testbench
===================================

# thread_scheduler

Parametrised successor to the single-slot thread manager: it holds up to NUM_THREADS active threads and a PEND_DEPTH-deep FIFO of threads waiting for admission. It sits between the CPU command decoder, which issues RUN and STOP requests, and the fetch controller, which asks for the next thread on every context switch. Stopping a thread is a linear address search over the active table. Round-robin dispatch gives newly admitted threads priority.

## Interface
- DATA_W, 64: per-thread context word width.
- ADDR_W, 32: thread entry/PC address width.
- NUM_THREADS, 8: active table depth, ≥2.
- PEND_DEPTH, 4: admission FIFO depth, ≥1.
- BOOT_EN, 1: reset preloads one boot thread into the FIFO.
- BOOT_ADDR, 0: boot thread address; boot context = 0.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- clk_oe  in  1  clock enable; when 0, all state and outputs hold; rst is also only sampled while 1.
- cmd_valid  in  1  command strobe, taken only when cmd_ready=1.
- cmd_op  in  2  0=NOP, 1=RUN, 2=STOP, 3=reserved (treated as NOP).
- cmd_data  in  DATA_W  RUN context word.
- cmd_addr  in  ADDR_W  RUN address / STOP match key.
- cmd_ready  out  1  FSM in IDLE.
- rsp_valid  out  1  one-cycle pulse ending every RUN/STOP.
- rsp_ok  out  1  1 = accepted/removed; data bus value is all-ones when 1, 0 when 0.
- rsp_data  out  DATA_W  {DATA_W{rsp_ok}}; 0 outside rsp_valid.
- next_req  in  1  level request for the next thread; hold until next_valid.
- next_valid  out  1  one-cycle pulse.
- next_none  out  1  with next_valid: no thread available.
- next_addr  out  ADDR_W  dispatched thread address.
- next_data  out  DATA_W  dispatched context.
- act_count  out  $clog2(NUM_THREADS+1)  number of active threads.
- pend_count  out  $clog2(PEND_DEPTH+1)  FIFO occupancy.

## Operation
- The active table is kept compact: entries 0..act_count-1 are valid. rr is the round-robin index.
- FSM states: IDLE, STOP_SCAN.
- IDLE, with cmd_valid and RUN:
  - Accept iff FIFO is not full and act_count+pend_count < NUM_THREADS.
  - On accept, push {cmd_data, cmd_addr}.
  - Respond next cycle, ok=accept.
- IDLE, with cmd_valid and STOP:
  - Latch the key, set scan index s=0, go to STOP_SCAN.
  - If act_count=0, respond ok=0 immediately and stay in IDLE.
- STOP_SCAN checks one entry per cycle; table[s].addr == key is a match.
  - On a match: copy table[act_count-1] into slot s, decrement act_count, respond ok=1, return to IDLE.
  - rr fix-up after removal: if rr > s, decrement rr. Then if rr ≥ new act_count, set rr=0.
  - No match at s=act_count-1: respond ok=0, return to IDLE.
  - STOP only searches active entries. Pending entries are never matched.
- Dispatch, taken only in IDLE when no command is accepted that cycle (commands have priority; next_req simply stays high):
  - FIFO non-empty: pop the head, write it to table[act_count], increment act_count, output it.
  - Else act_count>0: output table[rr], then rr = (rr+1 == act_count) ? 0 : rr+1.
  - Else: next_valid=1, next_none=1, next_addr/next_data=0.
- The capacity invariant act_count+pend_count ≤ NUM_THREADS guarantees an admission never overflows the table.

## Timing
- Reset (rst=1 with clk_oe=1):
  - act_count=0, rr=0, FSM=IDLE, cmd_ready=1.
  - rsp_valid, rsp_ok, next_valid, next_none = 0; next_addr/data and rsp_data = 0.
  - FIFO empty, except that with BOOT_EN the FIFO holds {0, BOOT_ADDR} and pend_count=1.
  - Reset mid-STOP_SCAN aborts the scan with no response.
- RUN latency: rsp_valid one cycle after acceptance.
- STOP latency: match at index s responds at cycle s+2 after acceptance. A miss responds at act_count+1. Empty table responds at 1.
- Dispatch latency: next_valid one cycle after the serviced next_req sample. next_req must be deasserted the cycle after next_valid, or a second dispatch follows.
- All outputs are registered. The count outputs reflect the updated values in the same cycle as the matching pulse.

## Structure
- Shared package thread_pkg: cmd_op encodings (NOP/RUN/STOP), FSM state enum, entry struct {data, addr}. These constants also belong in the existing inter-CPU message header.
- One sub-module, sched_fifo: parametrised synchronous FIFO with push, pop, full, empty, count, and a reset-preload option. The active table and FSM stay in the top level.

## Test plan
- Reset with BOOT_EN=1, BOOT_ADDR=0x100, then hold next_req: next_valid, next_addr=0x100, act_count=1, pend_count=0. A second request returns 0x100 again.
- RUN addresses 0x10, 0x20, 0x30, then 5 dispatches: order 0x10, 0x20, 0x30 (admissions), then round-robin 0x100, 0x10.
- Fill to NUM_THREADS=8 via RUN, then a ninth RUN: rsp_ok=0, rsp_data=0, counts unchanged. A RUN with the FIFO full but table space left also returns ok=0.
- Four active threads {A, B, C, D}, rr=2, STOP B: response at cycle 3 with ok=1. Table becomes {A, D, C}, rr=1. Next dispatch returns D.
- STOP on an unknown address with 4 active: ok=0 after 5 cycles; a next_req held during the scan is serviced in the cycle after the response.
- clk_oe=0 for 10 cycles mid-scan with next_req high: no state or output change. Resuming completes with the same latency.

Source files
------------

// File: rtl/thread_pkg.sv
// Shared thread-scheduler encodings: command opcodes, FSM states and the
// default-width {data, addr} entry layout used in the inter-CPU message header.
package thread_pkg;

  localparam int unsigned ENTRY_DATA_W = 64;
  localparam int unsigned ENTRY_ADDR_W = 32;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_RUN  = 2'd1,
    OP_STOP = 2'd2,
    OP_RSVD = 2'd3
  } cmd_op_e;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_STOP_SCAN = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic [ENTRY_DATA_W-1:0] data;
    logic [ENTRY_ADDR_W-1:0] addr;
  } entry_t;

  // Only RUN and STOP consume a command slot; NOP and the reserved code do not.
  function automatic logic is_cmd_op(input logic [1:0] op);
    return (op == OP_RUN) || (op == OP_STOP);
  endfunction

endpackage

// File: rtl/thread_scheduler_if.sv
// Command, response and dispatch signals between the CPU-side agents
// (command decoder, fetch controller) and thread_scheduler.
interface thread_scheduler_if #(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned NUM_THREADS = 8,
  parameter int unsigned PEND_DEPTH  = 4
);
  localparam int unsigned ACT_W  = $clog2(NUM_THREADS + 1);
  localparam int unsigned PEND_W = $clog2(PEND_DEPTH + 1);

  logic              clk_oe;
  logic              cmd_valid;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_ready;
  logic              rsp_valid;
  logic              rsp_ok;
  logic [DATA_W-1:0] rsp_data;
  logic              next_req;
  logic              next_valid;
  logic              next_none;
  logic [ADDR_W-1:0] next_addr;
  logic [DATA_W-1:0] next_data;
  logic [ACT_W-1:0]  act_count;
  logic [PEND_W-1:0] pend_count;

  modport master (
    output clk_oe, cmd_valid, cmd_op, cmd_data, cmd_addr, next_req,
    input  cmd_ready, rsp_valid, rsp_ok, rsp_data,
    input  next_valid, next_none, next_addr, next_data, act_count, pend_count
  );

  modport slave (
    input  clk_oe, cmd_valid, cmd_op, cmd_data, cmd_addr, next_req,
    output cmd_ready, rsp_valid, rsp_ok, rsp_data,
    output next_valid, next_none, next_addr, next_data, act_count, pend_count
  );

endinterface

// File: rtl/sched_fifo.sv
// Synchronous FIFO with clock enable and an optional single-entry preload
// applied on reset (used for the boot thread).
module sched_fifo #(
  parameter int unsigned       WIDTH       = 96,
  parameter int unsigned       DEPTH       = 4,
  parameter bit                PRELOAD_EN  = 1'b0,
  parameter logic [WIDTH-1:0]  PRELOAD_VAL = '0,
  localparam int unsigned      CNT_W       = $clog2(DEPTH + 1),
  localparam int unsigned      PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 32'd1) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_push  = i_push && (!o_full || i_pop);
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // Pointer, occupancy and storage update; everything holds while i_en is low.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (rst) begin
        r_rd_ptr <= '0;
        if (PRELOAD_EN) begin
          r_mem[0] <= PRELOAD_VAL;
          r_wr_ptr <= ptr_inc('0);
          r_count  <= CNT_W'(1);
        end else begin
          r_wr_ptr <= '0;
          r_count  <= '0;
        end
      end else begin
        if (w_push) begin
          r_mem[r_wr_ptr] <= i_push_data;
          r_wr_ptr        <= ptr_inc(r_wr_ptr);
        end
        if (w_pop) begin
          r_rd_ptr <= ptr_inc(r_rd_ptr);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: rtl/thread_scheduler.sv
// Thread scheduler: compact active table with round-robin dispatch, linear
// STOP search, and an admission FIFO whose entries dispatch ahead of the table.
module thread_scheduler
  import thread_pkg::*;
#(
  parameter int unsigned      DATA_W      = 64,
  parameter int unsigned      ADDR_W      = 32,
  parameter int unsigned      NUM_THREADS = 8,
  parameter int unsigned      PEND_DEPTH  = 4,
  parameter bit               BOOT_EN     = 1'b1,
  parameter logic [ADDR_W-1:0] BOOT_ADDR  = '0
) (
  input logic                clk,
  input logic                rst,
  thread_scheduler_if.slave  bus
);

  localparam int unsigned ACT_W  = $clog2(NUM_THREADS + 1);
  localparam int unsigned IDX_W  = $clog2(NUM_THREADS);
  localparam int unsigned PEND_W = $clog2(PEND_DEPTH + 1);
  localparam int unsigned SLOT_W = DATA_W + ADDR_W;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } slot_t;

  localparam logic [SLOT_W-1:0] BOOT_SLOT = {{DATA_W{1'b0}}, BOOT_ADDR};

  sched_state_e      r_state;
  logic              r_cmd_ready;
  slot_t             r_table [NUM_THREADS];
  logic [ACT_W-1:0]  r_act_count;
  logic [IDX_W-1:0]  r_rr;
  logic [IDX_W-1:0]  r_scan;
  logic [ADDR_W-1:0] r_key;
  logic              r_rsp_valid;
  logic              r_rsp_ok;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_next_valid;
  logic              r_next_none;
  logic [ADDR_W-1:0] r_next_addr;
  logic [DATA_W-1:0] r_next_data;

  slot_t             w_fifo_head;
  slot_t             w_push_slot;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [PEND_W-1:0] w_pend_count;
  logic              w_cmd_take;
  logic              w_is_run;
  logic              w_run_ok;
  logic              w_dispatch;
  logic              w_push;
  logic              w_pop;
  logic [31:0]       w_occupancy;
  logic [ACT_W-1:0]  w_count_dec;
  logic [IDX_W-1:0]  w_tail_idx;
  logic              w_hit;
  logic              w_last;
  logic [IDX_W-1:0]  w_rr_dec;
  logic [IDX_W-1:0]  w_rr_after_stop;
  logic [IDX_W-1:0]  w_rr_next;

  assign w_push_slot = '{data: bus.cmd_data, addr: bus.cmd_addr};

  sched_fifo #(
    .WIDTH       (SLOT_W),
    .DEPTH       (PEND_DEPTH),
    .PRELOAD_EN  (BOOT_EN),
    .PRELOAD_VAL (BOOT_SLOT)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_en        (bus.clk_oe),
    .i_push      (w_push),
    .i_push_data (w_push_slot),
    .i_pop       (w_pop),
    .o_head      (w_fifo_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_pend_count)
  );

  // Command/dispatch arbitration, admission check and table index arithmetic.
  always_comb begin
    w_occupancy = 32'(r_act_count) + 32'(w_pend_count);
    w_is_run    = (bus.cmd_op == OP_RUN);
    if (r_state == ST_IDLE) begin
      w_cmd_take = bus.cmd_valid && is_cmd_op(bus.cmd_op);
      w_dispatch = !w_cmd_take && bus.next_req;
    end else begin
      w_cmd_take = 1'b0;
      w_dispatch = 1'b0;
    end
    // Capacity check keeps every pending entry guaranteed a table slot.
    w_run_ok    = w_cmd_take && w_is_run && !w_fifo_full &&
                  (w_occupancy < 32'(NUM_THREADS));
    w_push      = w_run_ok;
    w_pop       = w_dispatch && !w_fifo_empty;

    w_count_dec = r_act_count - ACT_W'(1);
    w_tail_idx  = IDX_W'(w_count_dec);
    w_hit       = (r_table[r_scan].addr == r_key);
    w_last      = (ACT_W'(r_scan) == w_count_dec);
    w_rr_dec    = (r_rr > r_scan) ? r_rr - IDX_W'(1) : r_rr;
    w_rr_after_stop = (ACT_W'(w_rr_dec) >= w_count_dec) ? '0 : w_rr_dec;
    w_rr_next   = ((ACT_W'(r_rr) + ACT_W'(1)) == r_act_count) ? '0 : r_rr + IDX_W'(1);
  end

  // Control FSM, active table and all registered outputs.
  always_ff @(posedge clk) begin
    if (bus.clk_oe) begin
      if (rst) begin
        r_state      <= ST_IDLE;
        r_cmd_ready  <= 1'b1;
        r_act_count  <= '0;
        r_rr         <= '0;
        r_scan       <= '0;
        r_key        <= '0;
        r_rsp_valid  <= 1'b0;
        r_rsp_ok     <= 1'b0;
        r_rsp_data   <= '0;
        r_next_valid <= 1'b0;
        r_next_none  <= 1'b0;
        r_next_addr  <= '0;
        r_next_data  <= '0;
      end else begin
        r_rsp_valid  <= 1'b0;
        r_rsp_ok     <= 1'b0;
        r_rsp_data   <= '0;
        r_next_valid <= 1'b0;
        r_next_none  <= 1'b0;
        r_next_addr  <= '0;
        r_next_data  <= '0;
        case (r_state)
          ST_IDLE: begin
            if (w_cmd_take && w_is_run) begin
              r_rsp_valid <= 1'b1;
              r_rsp_ok    <= w_run_ok;
              r_rsp_data  <= {DATA_W{w_run_ok}};
            end else if (w_cmd_take) begin
              if (r_act_count == '0) begin
                r_rsp_valid <= 1'b1;
              end else begin
                r_key       <= bus.cmd_addr;
                r_scan      <= '0;
                r_state     <= ST_STOP_SCAN;
                r_cmd_ready <= 1'b0;
              end
            end else if (w_dispatch) begin
              r_next_valid <= 1'b1;
              if (!w_fifo_empty) begin
                r_table[IDX_W'(r_act_count)] <= w_fifo_head;
                r_act_count <= r_act_count + ACT_W'(1);
                r_next_addr <= w_fifo_head.addr;
                r_next_data <= w_fifo_head.data;
              end else if (r_act_count != '0) begin
                r_next_addr <= r_table[r_rr].addr;
                r_next_data <= r_table[r_rr].data;
                r_rr        <= w_rr_next;
              end else begin
                r_next_none <= 1'b1;
              end
            end else begin
              r_state <= ST_IDLE;
            end
          end
          ST_STOP_SCAN: begin
            if (w_hit) begin
              // Move the tail entry into the hole so the table stays compact.
              r_table[r_scan] <= r_table[w_tail_idx];
              r_act_count     <= w_count_dec;
              r_rr            <= w_rr_after_stop;
              r_rsp_valid     <= 1'b1;
              r_rsp_ok        <= 1'b1;
              r_rsp_data      <= '1;
              r_state         <= ST_IDLE;
              r_cmd_ready     <= 1'b1;
            end else if (w_last) begin
              r_rsp_valid <= 1'b1;
              r_state     <= ST_IDLE;
              r_cmd_ready <= 1'b1;
            end else begin
              r_scan <= r_scan + IDX_W'(1);
            end
          end
          default: begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.cmd_ready  = r_cmd_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_ok     = r_rsp_ok;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.next_valid = r_next_valid;
  assign bus.next_none  = r_next_none;
  assign bus.next_addr  = r_next_addr;
  assign bus.next_data  = r_next_data;
  assign bus.act_count  = r_act_count;
  assign bus.pend_count = w_pend_count;

endmodule

// File: tb/tb_thread_scheduler.sv
// Self-checking bench for thread_scheduler: directed scenarios followed by
// randomized traffic, all checked against a queue-based behavioural model.
module tb_thread_scheduler;
  import thread_pkg::*;

  localparam int unsigned DATA_W      = 64;
  localparam int unsigned ADDR_W      = 32;
  localparam int          NUM_THREADS = 8;
  localparam int          PEND_DEPTH  = 4;
  localparam logic [31:0] BOOT_ADDR   = 32'h100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  entry_t pend_q[$];
  entry_t act_q[$];
  int     rr;

  thread_scheduler_if #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_THREADS(NUM_THREADS), .PEND_DEPTH(PEND_DEPTH)
  ) bus ();

  thread_scheduler #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_THREADS(NUM_THREADS), .PEND_DEPTH(PEND_DEPTH),
    .BOOT_EN(1'b1), .BOOT_ADDR(BOOT_ADDR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  task automatic model_reset();
    pend_q.delete();
    act_q.delete();
    pend_q.push_back('{data: 64'd0, addr: BOOT_ADDR});
    rr = 0;
  endtask

  function automatic logic model_run_ok();
    return (pend_q.size() < PEND_DEPTH) && (act_q.size() + pend_q.size() < NUM_THREADS);
  endfunction

  task automatic model_dispatch(output logic none, output entry_t e);
    none = 1'b0;
    e    = '0;
    if (pend_q.size() > 0) begin
      e = pend_q.pop_front();
      act_q.push_back(e);
    end else if (act_q.size() > 0) begin
      e  = act_q[rr];
      rr = (rr + 1) % act_q.size();
    end else begin
      none = 1'b1;
    end
  endtask

  task automatic model_stop(input logic [31:0] key, output logic ok, output int lat);
    int idx = -1;
    foreach (act_q[i]) if (idx < 0 && act_q[i].addr == key) idx = i;
    ok = 1'b0;
    if (act_q.size() == 0) begin
      lat = 1;
    end else if (idx < 0) begin
      lat = act_q.size() + 1;
    end else begin
      ok  = 1'b1;
      lat = idx + 2;
      act_q[idx] = act_q[act_q.size() - 1];
      void'(act_q.pop_back());
      if (rr > idx) rr--;
      if (rr >= act_q.size()) rr = 0;
    end
  endtask

  // ---------------- DUT drivers ----------------
  task automatic check_counts(input string tag);
    check({tag, "_act"},  64'(bus.act_count),  64'(act_q.size()));
    check({tag, "_pend"}, 64'(bus.pend_count), 64'(pend_q.size()));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.clk_oe = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'd0;
    bus.next_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    check("rst_ready",     64'(bus.cmd_ready),  64'd1);
    check("rst_rsp_valid", 64'(bus.rsp_valid),  64'd0);
    check("rst_rsp_ok",    64'(bus.rsp_ok),     64'd0);
    check("rst_rsp_data",  bus.rsp_data,        64'd0);
    check("rst_next_vld",  64'(bus.next_valid), 64'd0);
    check("rst_next_none", 64'(bus.next_none),  64'd0);
    check("rst_next_addr", 64'(bus.next_addr),  64'd0);
    check("rst_next_data", bus.next_data,       64'd0);
    check_counts("rst");
  endtask

  task automatic do_run(input logic [31:0] addr, input logic [63:0] data);
    logic ok;
    ok = model_run_ok();
    if (ok) pend_q.push_back('{data: data, addr: addr});
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd1;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    check("run_valid", 64'(bus.rsp_valid), 64'd1);
    check("run_ok",    64'(bus.rsp_ok),    64'(ok));
    check("run_data",  bus.rsp_data,       {64{ok}});
    check_counts("run");
  endtask

  task automatic check_dispatch(input string tag);
    logic   none;
    entry_t e;
    model_dispatch(none, e);
    check({tag, "_valid"}, 64'(bus.next_valid), 64'd1);
    check({tag, "_none"},  64'(bus.next_none),  64'(none));
    check({tag, "_addr"},  64'(bus.next_addr),  64'(e.addr));
    check({tag, "_data"},  bus.next_data,       e.data);
    check_counts(tag);
  endtask

  task automatic do_next();
    bus.next_req = 1'b1;
    tick();
    bus.next_req = 1'b0;
    check_dispatch("next");
  endtask

  task automatic do_stop(input logic [31:0] key, input logic hold_next, input int gate_at);
    logic ok;
    int   lat_exp;
    int   lat;
    int   cnt_before;
    cnt_before = act_q.size();
    model_stop(key, ok, lat_exp);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd2;
    bus.cmd_addr  = key;
    bus.next_req  = hold_next;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 30) begin
      check("scan_ready", 64'(bus.cmd_ready),  64'd0);
      check("scan_next",  64'(bus.next_valid), 64'd0);
      if (lat == gate_at) begin
        bus.clk_oe = 1'b0;
        repeat (10) begin
          tick();
          check("gate_ready", 64'(bus.cmd_ready),  64'd0);
          check("gate_rsp",   64'(bus.rsp_valid),  64'd0);
          check("gate_next",  64'(bus.next_valid), 64'd0);
          check("gate_act",   64'(bus.act_count),  64'(cnt_before));
        end
        bus.clk_oe = 1'b1;
      end
      tick();
      lat++;
    end
    check("stop_lat",   64'(lat),           64'(lat_exp));
    check("stop_ok",    64'(bus.rsp_ok),    64'(ok));
    check("stop_data",  bus.rsp_data,       {64{ok}});
    check("stop_ready", 64'(bus.cmd_ready), 64'd1);
    check_counts("stop");
    if (hold_next) begin
      tick();
      bus.next_req = 1'b0;
      check_dispatch("held_next");
    end
  endtask

  task automatic do_nop(input logic [1:0] op);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = 32'h100;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    check("nop_rsp",   64'(bus.rsp_valid), 64'd0);
    check("nop_ready", 64'(bus.cmd_ready), 64'd1);
    check_counts("nop");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    bus.clk_oe    = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_data  = 64'd0;
    bus.cmd_addr  = 32'd0;
    bus.next_req  = 1'b0;
    rr = 0;

    // Boot thread admission and single-thread round robin.
    do_reset();
    do_next();
    check("boot_addr", 64'(bus.next_addr), 64'h100);
    do_next();
    check("boot_again", 64'(bus.next_addr), 64'h100);

    // Admissions dispatch first, then round robin resumes.
    do_run(32'h10, 64'hA0);
    do_run(32'h20, 64'hB0);
    do_run(32'h30, 64'hC0);
    repeat (5) do_next();
    check("rr_fifth", 64'(bus.next_addr), 64'h10);

    // Fill to capacity; rejected RUNs leave counts unchanged.
    for (int i = 4; i < 8; i++) do_run(32'(i * 16), 64'(i));
    do_run(32'h80, 64'h80);
    repeat (4) do_next();
    do_run(32'h90, 64'h90);
    check("full_act", 64'(bus.act_count), 64'd8);
    do_stop(32'h70, 1'b0, -1);

    // FIFO full with table space left, then STOP fix-up scenario.
    do_reset();
    do_run(32'h200, 64'h2);
    do_run(32'h300, 64'h3);
    do_run(32'h400, 64'h4);
    do_run(32'h500, 64'h5);
    check("fifo_full_rej", 64'(bus.rsp_ok), 64'd0);
    repeat (6) do_next();
    do_stop(32'h200, 1'b0, -1);
    do_next();
    check("after_stop_d", 64'(bus.next_addr), 64'h400);

    // Miss with next_req held, then clock-enable pause mid-scan.
    do_run(32'h500, 64'h5);
    do_next();
    do_stop(32'hDEAD, 1'b1, -1);
    do_stop(32'h500, 1'b1, 2);

    // Empty table: pending boot entry is never matched; empty dispatch.
    do_reset();
    do_stop(32'h100, 1'b0, -1);
    do_next();
    do_stop(32'h100, 1'b0, -1);
    do_next();
    check("none_flag", 64'(bus.next_none), 64'd1);

    // Reset while scanning aborts without a response.
    do_next();
    do_run(32'h10, 64'h1);
    do_next();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd2;
    bus.cmd_addr  = 32'hBAD;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check("abort_rsp",   64'(bus.rsp_valid), 64'd0);
    check("abort_ready", 64'(bus.cmd_ready), 64'd1);
    check_counts("abort");
    tick();
    check("abort_late", 64'(bus.rsp_valid), 64'd0);

    do_nop(2'd0);
    do_nop(2'd3);

    // Randomized traffic over a small address pool so STOPs hit often.
    for (int n = 0; n < 300; n++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      a = 32'h1000 + 32'($urandom_range(0, 11)) * 32'd4;
      if (sel <= 3) begin
        do_run(a, {$urandom, $urandom});
      end else if (sel <= 5) begin
        do_stop(a, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : -1);
      end else if (sel <= 8) begin
        do_next();
      end else begin
        do_nop(($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
